// File: rtl/switch_event_pkg.sv
// rtl/switch_event_pkg.sv - event type codes and channel FSM states for switch_event_ctrl
package switch_event_pkg;

  localparam logic [1:0] EV_RELEASE = 2'd0;
  localparam logic [1:0] EV_PRESS   = 2'd1;
  localparam logic [1:0] EV_LONG    = 2'd2;

  typedef enum logic {
    IDLE,
    SETTLE
  } chan_state_t;

endpackage

// File: rtl/switch_event_chan.sv
// rtl/switch_event_chan.sv - one switch channel: synchroniser, debounce FSM, optional long-press counter
// Long-press detection is built only when LONG_PRESS_EN is defined.
module switch_event_chan
  import switch_event_pkg::*;
#(
  parameter logic [15:0] SETTLE_TICKS = 16'd64,
  parameter logic [15:0] LONG_TICKS   = 16'd2048
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       in_switch,
  output logic       out_switch,
  output logic       ev,
  output logic [1:0] ev_type
);

  logic        sync1;
  logic        s;
  chan_state_t state, state_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic        out_nxt;
  logic        settle_ev;

  // Reset preloads the whole path with the live input so no edge is seen on exit.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1      <= in_switch;
      s          <= in_switch;
      out_switch <= in_switch;
      state      <= IDLE;
      cnt        <= '0;
    end else begin
      sync1      <= in_switch;
      s          <= sync1;
      out_switch <= out_nxt;
      state      <= state_nxt;
      cnt        <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    out_nxt   = out_switch;
    settle_ev = 1'b0;
    case (state)
      IDLE: begin
        if (s != out_switch) begin
          state_nxt = SETTLE;
          cnt_nxt   = SETTLE_TICKS;
        end
      end
      SETTLE: begin
        if (s == out_switch) begin
          state_nxt = IDLE;
        end else if (cnt == 16'd0) begin
          out_nxt   = s;
          settle_ev = 1'b1;
          state_nxt = IDLE;
        end else if (tick) begin
          cnt_nxt = cnt - 16'd1;
        end
      end
    endcase
  end

`ifdef LONG_PRESS_EN
  logic [15:0] long_cnt;
  logic        long_ev;

  // Counter saturates at LONG_TICKS, so only one long event fires per press.
  assign long_ev = out_switch && tick && (long_cnt == LONG_TICKS - 16'd1);

  always_ff @(posedge clk) begin
    if (rst || !out_switch) begin
      long_cnt <= '0;
    end else if (tick && long_cnt != LONG_TICKS) begin
      long_cnt <= long_cnt + 16'd1;
    end
  end

  assign ev      = settle_ev | long_ev;
  assign ev_type = settle_ev ? (s ? EV_PRESS : EV_RELEASE) : EV_LONG;
`else
  assign ev      = settle_ev;
  assign ev_type = s ? EV_PRESS : EV_RELEASE;
`endif

endmodule

// File: rtl/switch_event_ctrl.sv
// rtl/switch_event_ctrl.sv - prescaler, per-channel debouncers, pending array and round-robin event port
// LONG_PRESS_EN enables type-2 long-press events in the channels.
module switch_event_ctrl
  import switch_event_pkg::*;
#(
  parameter int          NUM_CH       = 4,
  parameter int          CH_W         = 2,
  parameter logic [31:0] TICK_DIV     = 32'h0000_8000,
  parameter logic [15:0] SETTLE_TICKS = 16'd64,
  parameter logic [15:0] LONG_TICKS   = 16'd2048
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] in_switch,
  output logic [NUM_CH-1:0] out_switch,
  output logic              ev_valid,
  output logic [CH_W-1:0]   ev_ch,
  output logic [1:0]        ev_type,
  input  logic              ev_ack,
  output logic [NUM_CH-1:0] ovf,
  input  logic              ovf_clr
);

  logic [31:0]       presc;
  logic              tick;
  logic [NUM_CH-1:0] ch_ev;
  logic [1:0]        ch_type [NUM_CH];
  logic [NUM_CH-1:0] pend;
  logic [1:0]        pend_type [NUM_CH];
  logic [CH_W-1:0]   ptr;
  logic [CH_W-1:0]   grant_ch;
  logic              found;
  logic              port_free;
  logic              grant_en;
  logic [NUM_CH-1:0] ovf_set;
  int                idx;

  assign tick = (presc == 32'd0);

  always_ff @(posedge clk) begin
    if (rst || tick) begin
      presc <= TICK_DIV - 32'd1;
    end else begin
      presc <= presc - 32'd1;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    switch_event_chan #(
      .SETTLE_TICKS(SETTLE_TICKS),
      .LONG_TICKS  (LONG_TICKS)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .tick      (tick),
      .in_switch (in_switch[g]),
      .out_switch(out_switch[g]),
      .ev        (ch_ev[g]),
      .ev_type   (ch_type[g])
    );
  end

  // Scan downward so the pending channel closest to ptr is the last to overwrite grant_ch.
  always_comb begin
    found    = 1'b0;
    grant_ch = ptr;
    idx      = 0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % NUM_CH;
      if (pend[idx]) begin
        found    = 1'b1;
        grant_ch = CH_W'(idx);
      end
    end
  end

  assign port_free = !ev_valid || ev_ack;
  assign grant_en  = port_free && found;

  // A pending event being granted this cycle is not lost, so it does not count as overflow.
  always_comb begin
    ovf_set = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ovf_set[i] = ch_ev[i] && pend[i] && !(grant_en && int'(grant_ch) == i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ev_valid <= 1'b0;
      ev_ch    <= '0;
      ev_type  <= EV_RELEASE;
      ptr      <= '0;
      pend     <= '0;
      ovf      <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        pend_type[i] <= EV_RELEASE;
      end
    end else begin
      if (port_free) begin
        ev_valid <= found;
        if (found) begin
          ev_ch   <= grant_ch;
          ev_type <= pend_type[grant_ch];
          ptr     <= (int'(grant_ch) == NUM_CH - 1) ? '0 : grant_ch + CH_W'(1);
        end
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_ev[i]) begin
          pend[i]      <= 1'b1;
          pend_type[i] <= ch_type[i];
        end else if (grant_en && int'(grant_ch) == i) begin
          pend[i] <= 1'b0;
        end
      end
      ovf <= (ovf & ~{NUM_CH{ovf_clr}}) | ovf_set;
    end
  end

endmodule

// File: tb/tb_switch_event_ctrl.sv
// tb/tb_switch_event_ctrl.sv - directed and randomized checks of switch_event_ctrl against a level/event model
module tb_switch_event_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] sw_in;
  logic [3:0] out_switch;
  logic       ev_valid;
  logic [1:0] ev_ch;
  logic [1:0] ev_type;
  logic       ev_ack;
  logic [3:0] ovf;
  logic       ovf_clr;

`ifdef LONG_PRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int ack_mode = 0;
  int pulse_req = 0;
  int pulse_done = 0;
  int cyc = 0;
  int stab_err = 0;
  logic [7:0] evq[$];
  int         evt[$];
  logic [7:0] rexp[$];
  logic [7:0] qa[$];
  logic [7:0] qe[$];

  switch_event_ctrl #(
    .NUM_CH(4), .CH_W(2), .TICK_DIV(32'd4), .SETTLE_TICKS(16'd3), .LONG_TICKS(16'd8)
  ) dut (
    .clk(clk), .rst(rst), .in_switch(sw_in), .out_switch(out_switch),
    .ev_valid(ev_valid), .ev_ch(ev_ch), .ev_type(ev_type), .ev_ack(ev_ack),
    .ovf(ovf), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [3:0] v);
    sw_in = v;
    rst = 1'b1;
    step(3);
    rst = 1'b0;
  endtask

  function automatic logic [7:0] ev_at(input int i);
    if (i < evq.size()) return evq[i];
    return 8'hff;
  endfunction

  // Ack driver: 0 = single acks on request, 1 = always, 2 = random.
  initial begin
    ev_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (ack_mode == 1) begin
        ev_ack = 1'b1;
      end else if (ack_mode == 2) begin
        ev_ack = ($urandom_range(0, 3) != 0);
      end else if (pulse_req != pulse_done && ev_valid) begin
        ev_ack = 1'b1;
        pulse_done++;
      end else begin
        ev_ack = 1'b0;
      end
    end
  end

  // Monitor: records accepted events and checks presented events hold until acked.
  initial begin
    logic       hold_prev;
    logic [1:0] prev_ch;
    logic [1:0] prev_type;
    hold_prev = 1'b0;
    prev_ch = '0;
    prev_type = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        hold_prev = 1'b0;
      end else begin
        if (hold_prev && !(ev_valid && ev_ch == prev_ch && ev_type == prev_type)) stab_err++;
        if (ev_valid && ev_ack) begin
          evq.push_back({4'd0, ev_ch, ev_type});
          evt.push_back(cyc);
        end
        hold_prev = ev_valid && !ev_ack;
        prev_ch = ev_ch;
        prev_type = ev_type;
      end
    end
  end

  initial begin
    int m;
    int n;
    logic [3:0] lvl;
    logic [3:0] nv;
    rst = 1'b1;
    sw_in = 4'b0101;
    ovf_clr = 1'b0;

    // Reset state and quiet period
    ack_mode = 1;
    do_reset(4'b0101);
    check("rst_out", out_switch, 4'b0101);
    check("rst_valid", ev_valid, 0);
    check("rst_ovf", ovf, 0);
    m = evq.size();
    step(100);
    check("rst_no_events", evq.size() - m, 0);
    check("rst_out_hold", out_switch, 4'b0101);

    // Ch1 rise: latency, event held until ack
    ack_mode = 0;
    do_reset(4'b0000);
    sw_in = 4'b0010;
    n = 0;
    while (!out_switch[1] && n < 40) begin
      @(posedge clk);
      n++;
      #1;
    end
    check($sformatf("lat_ch1 n=%0d in 12..16", n), (n >= 12 && n <= 16), 1);
    step(3);
    check("ch1_valid", ev_valid, 1);
    check("ch1_ch", ev_ch, 1);
    check("ch1_type", ev_type, 1);
    step(20);
    check("ch1_held", {ev_valid, ev_ch, ev_type}, {1'b1, 2'd1, 2'd1});
    pulse_req++;
    step(3);
    check("ch1_after_ack", ev_valid, 0);

    // Ch2 glitch rejected
    m = evq.size();
    sw_in = 4'b0110;
    step(6);
    sw_in = 4'b0010;
    step(30);
    check("glitch_out", out_switch, 4'b0010);
    check("glitch_valid", ev_valid, 0);
    check("glitch_no_ev", evq.size() - m, 0);

    // Simultaneous ch0/ch3 with continuous ack: rotation order
    ack_mode = 1;
    do_reset(4'b0000);
    m = evq.size();
    sw_in = 4'b1001;
    step(30);
    check("pair1_n", evq.size() - m, 2);
    check("pair1_first", ev_at(m), 8'h01);
    check("pair1_second", ev_at(m + 1), 8'h0D);
    if (evq.size() - m >= 2) check("pair1_b2b", evt[m + 1] - evt[m], 1);
    m = evq.size();
    sw_in = 4'b0000;
    step(30);
    check("pair2_n", evq.size() - m, 2);
    check("pair2_first", ev_at(m), 8'h00);
    check("pair2_second", ev_at(m + 1), 8'h0C);
    if (evq.size() - m >= 2) check("pair2_b2b", evt[m + 1] - evt[m], 1);

    // Overflow on ch1 while its press is presented and unacked
    ack_mode = 0;
    do_reset(4'b0000);
    sw_in = 4'b0010;
    step(25);
    sw_in = 4'b0000;
    step(25);
    check("ovf_none_yet", ovf, 0);
    sw_in = 4'b0010;
    step(25);
    sw_in = 4'b0000;
    step(25);
    check("ovf_set", ovf, 4'b0010);
    check("ovf_presented", {ev_valid, ev_ch, ev_type}, {1'b1, 2'd1, 2'd1});
    pulse_req++;
    step(3);
    check("ovf_next", {ev_valid, ev_ch, ev_type}, {1'b1, 2'd1, 2'd0});
    ovf_clr = 1'b1;
    step(1);
    ovf_clr = 1'b0;
    check("ovf_clr", ovf, 0);
    pulse_req++;
    step(3);
    check("ovf_drained", ev_valid, 0);

`ifdef LONG_PRESS_EN
    // Long press on ch0
    ack_mode = 1;
    do_reset(4'b0000);
    m = evq.size();
    sw_in = 4'b0001;
    step(60);
    check("long_first", ev_at(m), 8'h01);
    check("long_second", ev_at(m + 1), 8'h02);
    if (evq.size() - m >= 2)
      check($sformatf("long_gap %0d in 28..33", evt[m + 1] - evt[m]),
            (evt[m + 1] - evt[m] >= 28 && evt[m + 1] - evt[m] <= 33), 1);
    step(60);
    check("long_once", evq.size() - m, 2);
    sw_in = 4'b0000;
    step(30);
    check("long_release", ev_at(m + 2), 8'h00);
`endif

    // Randomized: stable holds produce one event per changed channel, glitches none
    ack_mode = 2;
    lvl = 4'($urandom);
    do_reset(lvl);
    step(5);
    m = evq.size();
    rexp.delete();
    for (int p = 0; p < 40; p++) begin
      if ($urandom_range(0, 3) == 0) begin
        sw_in = lvl ^ 4'($urandom_range(1, 15));
        step($urandom_range(1, 6));
        sw_in = lvl;
        step(30);
      end else begin
        nv = 4'($urandom);
        for (int c = 0; c < 4; c++)
          if (nv[c] != lvl[c]) rexp.push_back({4'd0, 2'(c), 1'b0, nv[c]});
        lvl = nv;
        sw_in = nv;
        step(45);
      end
    end
    step(40);
    check("rnd_out", out_switch, lvl);
    check("rnd_ovf", ovf, 0);
    for (int c = 0; c < 4; c++) begin
      qa.delete();
      qe.delete();
      for (int i = m; i < evq.size(); i++)
        if (evq[i][3:2] == 2'(c) && !(LONG_EN && evq[i][1:0] == 2'd2)) qa.push_back(evq[i]);
      for (int i = 0; i < rexp.size(); i++)
        if (rexp[i][3:2] == 2'(c)) qe.push_back(rexp[i]);
      check($sformatf("rnd_ch%0d_count", c), qa.size(), qe.size());
      for (int i = 0; i < qa.size() && i < qe.size(); i++)
        check($sformatf("rnd_ch%0d_ev%0d", c, i), qa[i], qe[i]);
    end
    check("stable_while_valid", stab_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
